hex_display_scheduler: RTL and testbench

- Owns the six active-low 7-segment digits (HEX0..HEX5) on the UART word-detector board and shares them between two requesters.
  - Live echo: a scrolling record of the last six received characters.
  - Banner: a six-digit message (e.g. "HELLO") held for a fixed time.
- Sequences the banner hold, with optional blink, and the post-banner clear in-block, replacing ad-hoc external counter handshakes.
- Sits between the UART receive/decoder path and the board HEX pins.

---
 rtl/hex_disp_pkg.sv | 11 +
 rtl/hex_display_scheduler_if.sv | 18 +
 rtl/hex_display_scheduler_banner_hold_timer.sv | 40 ++++
 rtl/hex_display_scheduler.sv | 81 ++++++++
 tb/tb_hex_display_scheduler.sv | 120 ++++++++++++
 5 files changed

// File: rtl/hex_disp_pkg.sv
// hex_disp_pkg: shared states, segment glyphs and banner constant for the HEX display scheduler
package hex_disp_pkg;
  typedef enum logic [1:0] {ECHO, BANNER, CLEAR} state_e;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_H = 8'h89;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_L = 8'hC7;
  localparam logic [7:0] SEG_O = 8'hA3;
  localparam logic [7:0] SEG_DP = 8'h7F;
  localparam logic [47:0] BANNER_HELLO = {SEG_H, SEG_E, SEG_L, SEG_L, SEG_O, SEG_BLANK};
endpackage

// File: rtl/hex_display_scheduler_if.sv
// hex_display_scheduler_if: requester-side character/banner signals and the six HEX digit outputs
interface hex_display_scheduler_if;
  logic char_valid;
  logic [7:0] char_seg;
  logic banner_req;
  logic [47:0] banner_seg;
  logic banner_ack;
  logic banner_active;
  logic [7:0] hex0, hex1, hex2, hex3, hex4, hex5;
  modport master (
    output char_valid, char_seg, banner_req, banner_seg,
    input banner_ack, banner_active, hex0, hex1, hex2, hex3, hex4, hex5
  );
  modport slave (
    input char_valid, char_seg, banner_req, banner_seg,
    output banner_ack, banner_active, hex0, hex1, hex2, hex3, hex4, hex5
  );
endinterface

// File: rtl/hex_display_scheduler_banner_hold_timer.sv
// banner_hold_timer: banner hold counter plus blink phase; lit is the phase of the following cycle
module banner_hold_timer #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int BLINK_CYCLES = 12_500_000,
  parameter int CNT_W = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic tc,
  output logic lit
);
  localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLINK_TC = CNT_W'(BLINK_CYCLES == 0 ? 0 : BLINK_CYCLES - 1);
  logic run_q, run_d, dark_q, dark_d, wrap;
  logic [CNT_W-1:0] hold_q, hold_d, blink_q, blink_d;
  assign tc = run_q && hold_q == HOLD_TC;
  assign wrap = BLINK_CYCLES != 0 && blink_q == BLINK_TC;
  // registered HEX needs the phase of the next cycle, so account for a toggle at this edge
  assign lit = !(dark_q ^ wrap);
  always_comb begin
    run_d = start | (run_q & !tc);
    hold_d = start ? '0 : run_q ? hold_q + CNT_W'(1) : hold_q;
    blink_d = start ? '0 : run_q ? (wrap ? '0 : blink_q + CNT_W'(1)) : blink_q;
    dark_d = start ? 1'b0 : dark_q ^ (run_q & wrap);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      dark_q <= 1'b0;
      hold_q <= '0;
      blink_q <= '0;
    end else begin
      run_q <= run_d;
      dark_q <= dark_d;
      hold_q <= hold_d;
      blink_q <= blink_d;
    end
  end
endmodule

// File: rtl/hex_display_scheduler.sv
// hex_display_scheduler: shares six HEX digits between a scrolling character echo and a timed banner
module hex_display_scheduler
  import hex_disp_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int BLINK_CYCLES = 12_500_000,
  parameter int CNT_W = 26
) (
  input logic clk,
  input logic rst,
  hex_display_scheduler_if.slave bus
);
  state_e state_q, state_d;
  logic [5:0][7:0] echo_q, echo_d, hex_q, hex_d;
  logic [47:0] banner_q, banner_d;
  logic ack_q, ack_d, active_q, active_d, accept, tc, lit;
  assign accept = state_q == ECHO && bus.banner_req;
  banner_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES),
    .BLINK_CYCLES(BLINK_CYCLES),
    .CNT_W(CNT_W)
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .start(accept),
    .tc(tc),
    .lit(lit)
  );
  always_comb begin
    state_d = state_q;
    banner_d = banner_q;
    echo_d = bus.char_valid ? {echo_q[4:0], bus.char_seg} : echo_q;
    hex_d = echo_d;
    ack_d = accept;
    active_d = 1'b0;
    case (state_q)
      ECHO: begin
        state_d = accept ? BANNER : ECHO;
        banner_d = accept ? bus.banner_seg : banner_q;
        hex_d = accept ? bus.banner_seg : echo_d;
        active_d = accept;
      end
      BANNER: begin
        state_d = tc ? CLEAR : BANNER;
        hex_d = (tc || !lit) ? {6{SEG_BLANK}} : banner_q;
        active_d = !tc;
      end
      CLEAR: begin
        state_d = ECHO;
        echo_d = {{5{SEG_BLANK}}, bus.char_valid ? bus.char_seg : SEG_BLANK};
        hex_d = echo_d;
      end
      default: state_d = ECHO;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ECHO;
      echo_q <= {6{SEG_BLANK}};
      hex_q <= {6{SEG_BLANK}};
      banner_q <= {6{SEG_BLANK}};
      ack_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q <= state_d;
      echo_q <= echo_d;
      hex_q <= hex_d;
      banner_q <= banner_d;
      ack_q <= ack_d;
      active_q <= active_d;
    end
  end
  assign bus.banner_ack = ack_q;
  assign bus.banner_active = active_q;
  assign bus.hex0 = hex_q[0];
  assign bus.hex1 = hex_q[1];
  assign bus.hex2 = hex_q[2];
  assign bus.hex3 = hex_q[3];
  assign bus.hex4 = hex_q[4];
  assign bus.hex5 = hex_q[5];
endmodule

// File: tb/tb_hex_display_scheduler.sv
// tb_hex_display_scheduler: vector table plus scoreboard checks for steady and blinking instances
module tb_hex_display_scheduler;
  import hex_disp_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  hex_display_scheduler_if b0 ();
  hex_display_scheduler_if b1 ();
  hex_display_scheduler #(.HOLD_CYCLES(8), .BLINK_CYCLES(0), .CNT_W(4)) d0 (.clk(clk), .rst(rst), .bus(b0));
  hex_display_scheduler #(.HOLD_CYCLES(8), .BLINK_CYCLES(2), .CNT_W(4)) d1 (.clk(clk), .rst(rst), .bus(b1));
  typedef struct packed {
    logic r;
    logic cv;
    logic [7:0] cs;
    logic br;
    logic [47:0] bs;
    logic [47:0] hex;
    logic ack;
    logic act;
  } vec_t;
  typedef struct packed {
    logic sel;
    logic [47:0] hex;
    logic ack;
    logic act;
  } exp_t;
  localparam logic [47:0] FF6 = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] HELLO = BANNER_HELLO;
  vec_t tbl[$];
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  logic [47:0] h0, h1;
  assign h0 = {b0.hex5, b0.hex4, b0.hex3, b0.hex2, b0.hex1, b0.hex0};
  assign h1 = {b1.hex5, b1.hex4, b1.hex3, b1.hex2, b1.hex1, b1.hex0};
  function automatic void add(logic r, logic cv, logic [7:0] cs, logic br, logic [47:0] bs,
                              logic [47:0] hex, logic ack, logic act);
    tbl.push_back('{r, cv, cs, br, bs, hex, ack, act});
  endfunction
  task automatic check(string nm, logic [47:0] got, logic [47:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask
  task automatic cyc(logic s, vec_t v, string nm);
    exp_t e;
    rst = v.r;
    b0.char_valid = v.cv;
    b0.char_seg = v.cs;
    b0.banner_req = v.br;
    b0.banner_seg = v.bs;
    b1.char_valid = v.cv;
    b1.char_seg = v.cs;
    b1.banner_req = v.br;
    b1.banner_seg = v.bs;
    sb.push_back('{s, v.hex, v.ack, v.act});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({nm, " hex"}, e.sel ? h1 : h0, e.hex);
    check({nm, " ack"}, 48'(e.sel ? b1.banner_ack : b0.banner_ack), 48'(e.ack));
    check({nm, " active"}, 48'(e.sel ? b1.banner_active : b0.banner_active), 48'(e.act));
  endtask
  task automatic idle(logic s, logic [47:0] hex, logic act, string nm);
    cyc(s, '{1'b0, 1'b0, 8'h00, 1'b0, 48'h0, hex, 1'b0, act}, nm);
  endtask
  initial begin
    logic [6:0] blink_lit;
    b0.char_valid = 0; b0.char_seg = 0; b0.banner_req = 0; b0.banner_seg = 0;
    b1.char_valid = 0; b1.char_seg = 0; b1.banner_req = 0; b1.banner_seg = 0;
    add(1, 0, 8'h00, 0, 48'h0, FF6, 0, 0);
    add(1, 0, 8'h00, 0, 48'h0, FF6, 0, 0);
    add(0, 1, 8'h89, 0, 48'h0, 48'hFFFF_FFFF_FF89, 0, 0);
    add(0, 1, 8'h86, 0, 48'h0, 48'hFFFF_FFFF_8986, 0, 0);
    add(0, 1, 8'hC7, 0, 48'h0, 48'hFFFF_FF89_86C7, 0, 0);
    add(0, 0, 8'h00, 0, 48'h0, 48'hFFFF_FF89_86C7, 0, 0);
    add(0, 1, 8'h01, 0, 48'h0, 48'hFFFF_8986_C701, 0, 0);
    add(0, 1, 8'h02, 0, 48'h0, 48'hFF89_86C7_0102, 0, 0);
    add(0, 1, 8'h03, 0, 48'h0, 48'h8986_C701_0203, 0, 0);
    add(0, 1, 8'h04, 0, 48'h0, 48'h86C7_0102_0304, 0, 0);
    add(0, 1, 8'h05, 0, 48'h0, 48'hC701_0203_0405, 0, 0);
    add(0, 1, 8'h06, 0, 48'h0, 48'h0102_0304_0506, 0, 0);
    add(0, 1, 8'h07, 0, 48'h0, 48'h0203_0405_0607, 0, 0);
    add(0, 0, 8'h00, 1, HELLO, HELLO, 1, 1);
    for (int k = 1; k < 8; k++) add(0, 0, 8'h00, k == 3, 48'h0, HELLO, 0, 1);
    add(0, 0, 8'h00, 0, 48'h0, FF6, 0, 0);
    add(0, 0, 8'h00, 0, 48'h0, FF6, 0, 0);
    add(0, 0, 8'h00, 0, 48'h0, FF6, 0, 0);
    add(0, 1, 8'h01, 1, HELLO, HELLO, 1, 1);
    for (int k = 1; k < 8; k++) add(0, 0, 8'h00, 0, 48'h0, HELLO, 0, 1);
    add(0, 1, 8'h55, 0, 48'h0, FF6, 0, 0);
    add(0, 1, 8'h86, 0, 48'h0, 48'hFFFF_FFFF_FF86, 0, 0);
    add(0, 0, 8'h00, 0, 48'h0, 48'hFFFF_FFFF_FF86, 0, 0);
    add(0, 0, 8'h00, 1, HELLO, HELLO, 1, 1);
    for (int k = 1; k < 8; k++) add(0, 0, 8'h00, 1, HELLO, HELLO, 0, 1);
    add(0, 0, 8'h00, 1, HELLO, FF6, 0, 0);
    add(0, 0, 8'h00, 1, HELLO, FF6, 0, 0);
    add(0, 0, 8'h00, 1, HELLO, HELLO, 1, 1);
    for (int k = 1; k < 8; k++) add(0, 0, 8'h00, 0, 48'h0, HELLO, 0, 1);
    add(0, 0, 8'h00, 0, 48'h0, FF6, 0, 0);
    add(0, 0, 8'h00, 0, 48'h0, FF6, 0, 0);
    foreach (tbl[i]) cyc(1'b0, tbl[i], $sformatf("row%0d", i));
    blink_lit = 7'b0011001;
    cyc(1'b1, '{1'b0, 1'b0, 8'h00, 1'b1, HELLO, HELLO, 1'b1, 1'b1}, "blink accept");
    for (int k = 0; k < 7; k++) idle(1'b1, blink_lit[k] ? HELLO : FF6, 1'b1, $sformatf("blink cnt%0d", k + 1));
    idle(1'b1, FF6, 1'b0, "blink clear");
    idle(1'b1, FF6, 1'b0, "blink echo");
    cyc(1'b0, '{1'b0, 1'b0, 8'h00, 1'b1, HELLO, HELLO, 1'b1, 1'b1}, "rstmid accept");
    for (int k = 1; k <= 4; k++) idle(1'b0, HELLO, 1'b1, $sformatf("rstmid cnt%0d", k));
    cyc(1'b0, '{1'b1, 1'b0, 8'h00, 1'b0, 48'h0, FF6, 1'b0, 1'b0}, "rstmid reset");
    cyc(1'b0, '{1'b0, 1'b0, 8'h00, 1'b1, HELLO, HELLO, 1'b1, 1'b1}, "rstmid reaccept");
    for (int k = 1; k < 8; k++) idle(1'b0, HELLO, 1'b1, $sformatf("rstmid hold%0d", k));
    idle(1'b0, FF6, 1'b0, "rstmid clear");
    idle(1'b0, FF6, 1'b0, "rstmid echo");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
